// File: rtl/main_memory.sv
// main_memory: line-wide single-port memory model behind a fixed-latency
// four-phase enable/ack handshake (IDLE -> BUSY -> ACK -> IDLE).
module main_memory #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_enable,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_data_in,
    output logic              mem_ack,
    output logic [LINE_W-1:0] mem_data_out
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              mem_we;

    // Line storage has no reset so its contents survive reset; it relies on
    // the zero power-up state of the target.
    logic [LINE_W-1:0] mem_q [DEPTH];

    // Offset bits and bits above the index never select a line.
    logic addr_unused;
    assign addr_unused = ^mem_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_enable) begin
                    rw_d    = mem_rw;
                    idx_d   = mem_addr[OFF_W +: IDX_W];
                    wdata_d = mem_data_in;
                    cnt_d   = 4'(LATENCY);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!mem_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    if (rw_q) begin
                        rdata_d = mem_q[idx_q];
                    end else begin
                        mem_we = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                if (!mem_enable) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
        rw_q    <= rw_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // Reset at the completion edge discards the pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_ack      = ack_q;
    assign mem_data_out = rdata_q;
endmodule

// File: tb/tb_main_memory.sv
// Directed self-checking bench for main_memory: default instance (LATENCY=5)
// plus a LATENCY=1 instance for the shortest-latency case.
module tb_main_memory;
    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 5;

    localparam logic [127:0] D1 = 128'hDEADBEEF_00000001_00000002_00000003;
    localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] D4 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D5 = 128'hCAFEF00D_BAADF00D_12345678_9ABCDEF0;
    localparam logic [127:0] D6 = 128'h77777777_66666666_55555555_44444444;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              mem_enable, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data_in;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data_out;

    logic              f_enable, f_rw;
    logic [ADDR_W-1:0] f_addr;
    logic [LINE_W-1:0] f_data_in;
    logic              f_ack;
    logic [LINE_W-1:0] f_data_out;

    int checks   = 0;
    int failures = 0;

    main_memory #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .mem_enable(mem_enable), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_ack(mem_ack), .mem_data_out(mem_data_out)
    );

    main_memory #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH), .LATENCY(1)) dut_fast (
        .clk(clk), .reset(reset), .mem_enable(f_enable), .mem_rw(f_rw),
        .mem_addr(f_addr), .mem_data_in(f_data_in),
        .mem_ack(f_ack), .mem_data_out(f_data_out)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full handshake on the default instance: the first edge after the
    // request is E0, so ack is seen after LATENCY+1 edges.
    task automatic applyStimulus(input string tag, input logic rw, input logic [31:0] addr,
                                 input logic [127:0] data, input int hold, output logic [127:0] rdata);
        int k;
        k = 0;
        mem_enable  = 1'b1;
        mem_rw      = rw;
        mem_addr    = addr;
        mem_data_in = data;
        while (mem_ack !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        checkOutput({tag, " ack latency"}, 128'(k), 128'(LATENCY + 1));
        rdata = mem_data_out;
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput({tag, " ack held"}, 128'(mem_ack), 128'd1);
        end
        mem_enable = 1'b0;
        tick();
        checkOutput({tag, " ack drop"}, 128'(mem_ack), 128'd0);
    endtask

    task automatic fastRequest(input string tag, input logic rw, input logic [31:0] addr,
                               input logic [127:0] data, output logic [127:0] rdata);
        int k;
        k = 0;
        f_enable  = 1'b1;
        f_rw      = rw;
        f_addr    = addr;
        f_data_in = data;
        while (f_ack !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        checkOutput({tag, " ack latency"}, 128'(k), 128'd2);
        rdata    = f_data_out;
        f_enable = 1'b0;
        tick();
        checkOutput({tag, " ack drop"}, 128'(f_ack), 128'd0);
    endtask

    initial begin
        logic [127:0] rd;
        logic         ack_seen;

        reset       = 1'b1;
        mem_enable  = 1'b0;
        mem_rw      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        f_enable    = 1'b0;
        f_rw        = 1'b0;
        f_addr      = '0;
        f_data_in   = '0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset ack", 128'(mem_ack), 128'd0);
        checkOutput("reset data_out", mem_data_out, 128'd0);
        checkOutput("reset fast ack", 128'(f_ack), 128'd0);

        // Write then read the same line, then aliases of it.
        applyStimulus("write 0x40", 1'b0, 32'h40, D1, 0, rd);
        checkOutput("write leaves data_out", mem_data_out, 128'd0);
        applyStimulus("read 0x40", 1'b1, 32'h40, '0, 0, rd);
        checkOutput("read 0x40 data", rd, D1);
        applyStimulus("read 0x4C", 1'b1, 32'h4C, '0, 0, rd);
        checkOutput("read 0x4C data", rd, D1);
        applyStimulus("read 0x1040", 1'b1, 32'h1040, '0, 0, rd);
        checkOutput("read 0x1040 data", rd, D1);

        // Abort: enable held through E0+3, dropped before E0+4.
        mem_enable  = 1'b1;
        mem_rw      = 1'b0;
        mem_addr    = 32'h40;
        mem_data_in = D2;
        ack_seen    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_ack === 1'b1) ack_seen = 1'b1;
        end
        mem_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_ack === 1'b1) ack_seen = 1'b1;
        end
        checkOutput("abort no ack", 128'(ack_seen), 128'd0);
        checkOutput("abort data_out", mem_data_out, D1);
        applyStimulus("read after abort", 1'b1, 32'h40, '0, 0, rd);
        checkOutput("abort line unchanged", rd, D1);

        // Ack held for 4 extra cycles, then a request on the very next edge.
        applyStimulus("hold read 0x4C", 1'b1, 32'h4C, '0, 4, rd);
        checkOutput("hold read data", rd, D1);
        applyStimulus("back2back write 0x100", 1'b0, 32'h100, D3, 0, rd);
        applyStimulus("read 0x100", 1'b1, 32'h100, '0, 0, rd);
        checkOutput("read 0x100 data", rd, D3);

        // Reset sampled at E0+2 of a write to 0x80.
        mem_enable  = 1'b1;
        mem_rw      = 1'b0;
        mem_addr    = 32'h80;
        mem_data_in = D6;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("reset mid ack", 128'(mem_ack), 128'd0);
        checkOutput("reset mid data_out", mem_data_out, 128'd0);
        reset      = 1'b0;
        mem_enable = 1'b0;
        ack_seen   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_ack === 1'b1) ack_seen = 1'b1;
        end
        checkOutput("reset mid no ack", 128'(ack_seen), 128'd0);
        applyStimulus("read 0x40 after reset", 1'b1, 32'h40, '0, 0, rd);
        checkOutput("line kept over reset", rd, D1);
        applyStimulus("read 0x80", 1'b1, 32'h80, '0, 0, rd);
        checkOutput("discarded write 0x80", rd, 128'd0);

        // Address/data changed after E0 must not affect the write.
        mem_enable  = 1'b1;
        mem_rw      = 1'b0;
        mem_addr    = 32'h00;
        mem_data_in = D4;
        tick();
        mem_addr    = 32'h40;
        mem_data_in = D5;
        mem_rw      = 1'b1;
        ack_seen    = 1'b0;
        for (int i = 0; i < 20 && !ack_seen; i++) begin
            tick();
            if (mem_ack === 1'b1) ack_seen = 1'b1;
        end
        checkOutput("late change ack", 128'(ack_seen), 128'd1);
        mem_enable = 1'b0;
        tick();
        applyStimulus("read 0x00", 1'b1, 32'h00, '0, 0, rd);
        checkOutput("line 0x00 E0 data", rd, D4);
        applyStimulus("read 0x40 untouched", 1'b1, 32'h40, '0, 0, rd);
        checkOutput("line 0x40 untouched", rd, D1);

        // LATENCY=1 instance.
        fastRequest("fast write 0x20", 1'b0, 32'h20, D5, rd);
        checkOutput("fast write data_out", f_data_out, 128'd0);
        fastRequest("fast read 0x20", 1'b1, 32'h20, '0, rd);
        checkOutput("fast read data", rd, D5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter LINE_W, default 128, bits per memory line (one transfer).
REQ-003 SHALL have parameter DEPTH, default 256, number of lines (power of two).
REQ-004 SHALL have parameter LATENCY, default 5, cycles from accepted request to ack; legal range 1..15.
REQ-005 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port mem_enable  in  1  request valid; held high by the requester until it sees mem_ack.
REQ-008 SHALL have port mem_rw  in  1  1 = read, 0 = write.
REQ-009 SHALL have port mem_addr  in  ADDR_W  byte address of the line.
REQ-010 SHALL have port mem_data_in  in  LINE_W  write data.
REQ-011 SHALL have port mem_ack  out  1  transfer complete; four-phase handshake.
REQ-012 SHALL have port mem_data_out  out  LINE_W  read data, valid while mem_ack=1 after a read.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and ACK.
REQ-014 SHALL, in IDLE at an edge E0 sampling mem_enable=1, latch mem_rw, mem_addr and mem_data_in, load a latency counter and go to BUSY.
REQ-015 SHALL ignore changes on mem_rw, mem_addr and mem_data_in after E0 until the next IDLE acceptance.
REQ-016 SHALL compute the line index as addr[log2(LINE_W/8) +: log2(DEPTH)], ignoring lower offset bits and wrapping higher bits modulo DEPTH.
REQ-017 SHALL, at edge E0+LATENCY while mem_enable is still 1, set mem_ack=1, go to ACK and perform the access.
REQ-018 SHALL, for a write, commit the latched data to the indexed line at that same edge.
REQ-019 SHALL, for a read, load mem_data_out from the indexed line at that same edge.
REQ-020 SHALL hold mem_ack=1 in ACK while mem_enable=1; at the first edge sampling mem_enable=0 it SHALL clear mem_ack and return to IDLE.
REQ-021 SHALL therefore accept a new request no earlier than the edge after mem_ack falls; back-to-back requests sustain one transfer per LATENCY+2 cycles.
REQ-022 SHALL abort when mem_enable is sampled 0 in BUSY: go to IDLE, no write, mem_ack stays 0, mem_data_out unchanged.
REQ-023 SHALL leave mem_data_out unchanged by writes and aborts; it holds the last read value indefinitely.
REQ-024 SHALL never assert mem_ack outside ACK and never perform more than one memory access per accepted request.
REQ-025 SHALL, for a read following a write to the same line, return the written data.
REQ-026 SHALL, for LATENCY=1, raise mem_ack at E0+1.

Reset
REQ-027 SHALL, on reset=1 at an edge, force state IDLE, mem_ack=0, mem_data_out=0 and counter=0, overriding all other actions at that edge.
REQ-028 SHALL, on reset during BUSY, discard the pending request with no write performed.
REQ-029 SHALL preserve line contents across reset; all lines SHALL be zero at time 0.

Verification
REQ-030 SHALL pass: write 0xDEADBEEF_00000001_00000002_00000003 to addr 0x40, then read 0x40 -> ack at E0+5 for both; read data equals the written value.
REQ-031 SHALL pass: read addr 0x4C after the 0x40 write (same line, offset bits differ) -> the same data; read addr 0x1040 (wraps to the 0x40 line, DEPTH=256, LINE_W=128) -> the same data.
REQ-032 SHALL pass: enable held for 3 cycles after acceptance then dropped -> mem_ack never rises, line unchanged, mem_data_out unchanged.
REQ-033 SHALL pass: requester holds enable 4 cycles after ack -> mem_ack stays 1 for those cycles, falls one cycle after enable falls, then a new request is accepted on the following edge.
REQ-034 SHALL pass: reset at E0+2 of a write to 0x80 -> mem_ack stays 0, subsequent read of 0x80 returns 0, mem_data_out=0 after reset.
REQ-035 SHALL pass: mem_addr and mem_data_in changed at E0+1 during a write to 0x00 -> line 0x00 holds the E0 values.
